load_store_unit: RTL



---
 rtl/load_store_unit.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/load_store_unit.sv
// Load/store sequencer between the execute stage and data memory: one request at a time,
// address/data set up a cycle before a single strobe and held for a cycle after it.
module load_store_unit #(
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 8,
  parameter int MEM_DEPTH   = 8,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              op_load,
  input  logic              op_store,
  input  logic [ADDR_W-1:0] base,
  input  logic [ADDR_W-1:0] offset,
  input  logic [DATA_W-1:0] wdata,
  input  logic [2:0]        rd_in,
  input  logic [DATA_W-1:0] Data_out,
  output logic              Rm,
  output logic              Wm,
  output logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] RegVal,
  output logic [DATA_W-1:0] load_data,
  output logic              wb_en,
  output logic [2:0]        wb_rd,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS, S_HOLD} state_e;

  localparam int                CNT_W    = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0]  CNT_INIT = CNT_W'(WAIT_CYCLES - 1);
  localparam logic [ADDR_W:0]   DEPTH_X  = (ADDR_W + 1)'(MEM_DEPTH);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                ld_q, ld_d;
  logic                st_q, st_d;
  logic [2:0]          rd_q, rd_d;
  logic                rm_q, rm_d;
  logic                wm_q, wm_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   regval_q, regval_d;
  logic [DATA_W-1:0]   ldata_q, ldata_d;
  logic                wb_en_q, wb_en_d;
  logic [2:0]          wb_rd_q, wb_rd_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic                bad_req;

  // An illegal op pair or an out-of-range address skips ACCESS so no strobe is ever raised.
  assign bad_req = ({1'b0, addr_q} >= DEPTH_X) || (ld_q && st_q);

  // Request handshake: start is a one-cycle valid sampled only in IDLE; there is no ready,
  // busy tells the issuer that a start now would be dropped rather than queued.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ld_d     = ld_q;
    st_d     = st_q;
    rd_d     = rd_q;
    rm_d     = rm_q;
    wm_d     = wm_q;
    addr_d   = addr_q;
    regval_d = regval_q;
    ldata_d  = ldata_q;
    wb_en_d  = wb_en_q;
    wb_rd_d  = wb_rd_q;
    busy_d   = busy_q;
    done_d   = done_q;
    err_d    = err_q;
    case (state_q)
      S_IDLE: begin
        if (start && (op_load || op_store)) begin
          state_d = S_SETUP;
          ld_d    = op_load;
          st_d    = op_store;
          rd_d    = rd_in;
          addr_d  = base + offset;
          if (op_store && !op_load) regval_d = wdata;
          busy_d  = 1'b1;
        end
      end
      S_SETUP: begin
        if (bad_req) begin
          state_d = S_HOLD;
          done_d  = 1'b1;
          err_d   = 1'b1;
        end else begin
          state_d = S_ACCESS;
          cnt_d   = CNT_INIT;
          rm_d    = ld_q;
          wm_d    = st_q;
        end
      end
      S_ACCESS: begin
        if (cnt_q == '0) begin
          state_d = S_HOLD;
          rm_d    = 1'b0;
          wm_d    = 1'b0;
          done_d  = 1'b1;
          if (ld_q) begin
            ldata_d = Data_out;
            wb_en_d = 1'b1;
            wb_rd_d = rd_q;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_HOLD: begin
        state_d = S_IDLE;
        done_d  = 1'b0;
        err_d   = 1'b0;
        wb_en_d = 1'b0;
        busy_d  = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      ld_q     <= 1'b0;
      st_q     <= 1'b0;
      rd_q     <= '0;
      rm_q     <= 1'b0;
      wm_q     <= 1'b0;
      addr_q   <= '0;
      regval_q <= '0;
      ldata_q  <= '0;
      wb_en_q  <= 1'b0;
      wb_rd_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ld_q     <= ld_d;
      st_q     <= st_d;
      rd_q     <= rd_d;
      rm_q     <= rm_d;
      wm_q     <= wm_d;
      addr_q   <= addr_d;
      regval_q <= regval_d;
      ldata_q  <= ldata_d;
      wb_en_q  <= wb_en_d;
      wb_rd_q  <= wb_rd_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign Rm        = rm_q;
  assign Wm        = wm_q;
  assign address   = addr_q;
  assign RegVal    = regval_q;
  assign load_data = ldata_q;
  assign wb_en     = wb_en_q;
  assign wb_rd     = wb_rd_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule
